// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings, limits and small helpers for the pipeline hazard controller.
// No logic of its own; no latency or backpressure.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 8;
  localparam int CNT_W  = 32;

  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = 8'd255;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: zero-cycle combinational compare of the ID sources against the EX load target.
// No flow control; the result is consumed the same cycle.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rt);
  assign rt_hit = id_uses_rt && (id_rt == ex_rt);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze outputs are combinational (zero latency).
// Memory busy freezes everything; a branch seen during a freeze is replayed once memory is ready.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             EX_BranchTaken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t            state;
  logic              pend_flush;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_rt),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rs  (ID_UsesRs),
    .id_uses_rt  (ID_UsesRt),
    .load_use    (load_use)
  );

  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl = '0;
    end else if (mem_busy) begin
      ctrl.pc_hold     = 1'b1;
      ctrl.if_id_hold  = 1'b1;
      ctrl.pipe_freeze = 1'b1;
    end else if (EX_BranchTaken || pend_flush) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_hold     = 1'b1;
      ctrl.if_id_hold  = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (ID_Jump) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign pc_hold     = ctrl.pc_hold;
  assign if_id_hold  = ctrl.if_id_hold;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign pipe_freeze = ctrl.pipe_freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pend_flush  <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (mem_busy) begin
        state      <= MEM_WAIT;
        // a branch resolved while frozen must not be lost; replay it on release
        pend_flush <= pend_flush | EX_BranchTaken;
        if (state == MEM_WAIT && wait_cnt != TIMEOUT_LIMIT) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt == TIMEOUT_LIMIT - WAIT_W'(1)) begin
            mem_timeout <= 1'b1;
          end
        end
      end else begin
        state      <= RUN;
        pend_flush <= 1'b0;
        wait_cnt   <= '0;
      end

      if (ctrl.pc_hold) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (ctrl.if_id_flush) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle expected control vectors go through a scoreboard queue.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken, mem_busy;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  logic [4:0]  ctrl_v;
  logic [4:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  // {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze}
  localparam logic [4:0] E_IDLE   = 5'b00000;
  localparam logic [4:0] E_STALL  = 5'b11010;
  localparam logic [4:0] E_FLUSH  = 5'b00110;
  localparam logic [4:0] E_JUMP   = 5'b00100;
  localparam logic [4:0] E_FREEZE = 5'b11001;

  assign ctrl_v = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze};

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Jump        (ID_Jump),
    .EX_MemRead     (EX_MemRead),
    .EX_rt          (EX_rt),
    .EX_BranchTaken (EX_BranchTaken),
    .mem_busy       (mem_busy),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .pipe_freeze    (pipe_freeze),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] ex, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    EX_MemRead = 1'b1; EX_rt = ex; ID_rs = rs; ID_UsesRs = urs; ID_rt = rt; ID_UsesRt = urt;
  endtask

  // Records the expectation for the cycle just driven and advances the counter model.
  task automatic push_exp(input logic [4:0] e);
    exp_q.push_back(e);
    if (reset) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (e[4]) exp_stall = exp_stall + 1;
      if (e[2]) exp_flush = exp_flush + 1;
    end
  endtask

  task automatic test_reset();
    logic [4:0] e;
    @(negedge clk);
    reset = 1'b1; idle(); mem_busy = 1'b1; EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
    set_load(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    push_exp(E_IDLE);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ctrl_v !== e) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_v, e);
    end
    @(negedge clk);
    checks++;
    if ({stall_cnt, flush_cnt, mem_timeout} !== 65'd0) begin
      failures++; $display("FAIL reset_regs stall=%0d flush=%0d timeout=%b exp all 0", stall_cnt, flush_cnt, mem_timeout);
    end
    checks++;
    if (dut.state !== RUN || dut.pend_flush !== 1'b0) begin
      failures++; $display("FAIL reset_state state=%b pend=%b exp 0 0", dut.state, dut.pend_flush);
    end
    idle(); reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [4:0] e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        failures++; $display("FAIL load_use_cnt row %0d stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      idle();
      case (i)
        0: begin set_load(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); push_exp(E_STALL); end
        1: push_exp(E_IDLE);
        2: begin set_load(5'd8, 5'd3, 1'b1, 5'd8, 1'b1); push_exp(E_STALL); end
        3: begin set_load(5'd8, 5'd8, 1'b0, 5'd8, 1'b0); push_exp(E_IDLE); end
        default: begin set_load(5'd8, 5'd8, 1'b1, 5'd8, 1'b1); EX_MemRead = 1'b0; push_exp(E_IDLE); end
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctrl_v !== e) begin
        failures++; $display("FAIL load_use row %0d got=%b exp=%b", i, ctrl_v, e);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        failures++; $display("FAIL zero_reg_cnt row %0d stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      idle();
      case (i)
        0: begin set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); push_exp(E_IDLE); end
        1: begin set_load(5'd0, 5'd5, 1'b1, 5'd0, 1'b1); push_exp(E_IDLE); end
        2: begin set_load(5'd31, 5'd31, 1'b1, 5'd0, 1'b0); push_exp(E_STALL); end
        default: push_exp(E_IDLE);
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctrl_v !== e) begin
        failures++; $display("FAIL zero_reg row %0d got=%b exp=%b", i, ctrl_v, e);
      end
    end
  endtask

  task automatic test_branch_priority();
    logic [4:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        failures++; $display("FAIL branch_cnt row %0d stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      idle();
      case (i)
        0: begin set_load(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); EX_BranchTaken = 1'b1; push_exp(E_FLUSH); end
        1: push_exp(E_IDLE);
        2: begin EX_BranchTaken = 1'b1; ID_Jump = 1'b1; push_exp(E_FLUSH); end
        3: begin ID_Jump = 1'b1; push_exp(E_JUMP); end
        4: begin ID_Jump = 1'b1; set_load(5'd12, 5'd0, 1'b0, 5'd12, 1'b1); push_exp(E_STALL); end
        default: push_exp(E_IDLE);
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctrl_v !== e) begin
        failures++; $display("FAIL branch_prio row %0d got=%b exp=%b", i, ctrl_v, e);
      end
    end
  endtask

  task automatic test_deferred_flush();
    logic [4:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        failures++; $display("FAIL deferred_cnt row %0d stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      idle();
      case (i)
        0: begin mem_busy = 1'b1; EX_BranchTaken = 1'b1; push_exp(E_FREEZE); end
        1: begin mem_busy = 1'b1; push_exp(E_FREEZE); end
        2: begin mem_busy = 1'b1; ID_Jump = 1'b1; set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); push_exp(E_FREEZE); end
        3: push_exp(E_FLUSH);
        default: push_exp(E_IDLE);
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctrl_v !== e) begin
        failures++; $display("FAIL deferred row %0d got=%b exp=%b", i, ctrl_v, e);
      end
      if (i == 1) begin
        checks++;
        if ({dut.state, dut.pend_flush} !== 2'b11) begin
          failures++; $display("FAIL deferred_pending state=%b pend=%b exp 1 1", dut.state, dut.pend_flush);
        end
      end
      if (i == 4) begin
        checks++;
        if ({dut.state, dut.pend_flush} !== 2'b00) begin
          failures++; $display("FAIL deferred_release state=%b pend=%b exp 0 0", dut.state, dut.pend_flush);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] e;
    logic [7:0] ew;
    logic       et;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        failures++; $display("FAIL timeout_cnt row %0d stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      idle();
      if (i < 300) begin
        mem_busy = 1'b1; push_exp(E_FREEZE);
      end else begin
        push_exp(E_IDLE);
      end
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctrl_v !== e) begin
        failures++; $display("FAIL timeout_ctrl row %0d got=%b exp=%b", i, ctrl_v, e);
      end
      ew = (i == 0) ? 8'd0 : ((i - 1 > 255) ? 8'd255 : 8'(i - 1));
      et = (i >= 256);
      checks++;
      if (dut.wait_cnt !== ew || mem_timeout !== et) begin
        failures++; $display("FAIL timeout_wait row %0d wait_cnt=%0d timeout=%b exp %0d %b", i, dut.wait_cnt, mem_timeout, ew, et);
      end
    end
    @(negedge clk);
    checks++;
    if (dut.wait_cnt !== 8'd0 || mem_timeout !== 1'b1 || dut.state !== RUN) begin
      failures++; $display("FAIL timeout_exit wait_cnt=%0d timeout=%b state=%b exp 0 1 0", dut.wait_cnt, mem_timeout, dut.state);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        failures++; $display("FAIL rst_wait_cnt row %0d stall=%0d flush=%0d exp %0d %0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      idle();
      reset = 1'b0;
      case (i)
        0: begin mem_busy = 1'b1; EX_BranchTaken = 1'b1; push_exp(E_FREEZE); end
        1: begin mem_busy = 1'b1; push_exp(E_FREEZE); end
        2: begin reset = 1'b1; mem_busy = 1'b1; push_exp(E_IDLE); end
        default: push_exp(E_IDLE);
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctrl_v !== e) begin
        failures++; $display("FAIL rst_wait row %0d got=%b exp=%b", i, ctrl_v, e);
      end
      if (i == 2) begin
        checks++;
        if ({dut.state, dut.pend_flush} !== 2'b11) begin
          failures++; $display("FAIL rst_wait_pre state=%b pend=%b exp 1 1", dut.state, dut.pend_flush);
        end
      end
      if (i == 3) begin
        checks++;
        if ({dut.state, dut.pend_flush, mem_timeout, dut.wait_cnt} !== 11'd0) begin
          failures++; $display("FAIL rst_wait_post state=%b pend=%b timeout=%b wait=%0d exp all 0", dut.state, dut.pend_flush, mem_timeout, dut.wait_cnt);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL rst_wait_final stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_priority();
    test_deferred_flush();
    test_timeout();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1 each  ID instruction reads rs / rt
- ID_Jump  in  1  J/JAL/JR resolved in ID
- EX_MemRead  in  1  EX instruction is a load
- EX_rt  in  5  load destination register
- EX_BranchTaken  in  1  branch in EX resolved taken
- mem_busy  in  1  data memory not ready; pipeline must freeze
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID register keeps its value
- if_id_flush  out  1  IF/ID register loads zeros
- id_ex_flush  out  1  ID/EX register loads bubble
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB registers hold
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  32  cycles with pc_hold=1
- flush_cnt  out  32  cycles with if_id_flush=1

Function
REQ-003 Control outputs SHALL be combinational from the inputs and the registered state (zero-cycle latency), so they take effect at the next clk edge of the pipeline registers.
REQ-004 FSM states SHALL be RUN and MEM_WAIT; pend_flush is a 1-bit register; wait_cnt is an 8-bit register.
REQ-005 load_use SHALL be EX_MemRead and EX_rt!=0 and ((ID_UsesRs and ID_rs==EX_rt) or (ID_UsesRt and ID_rt==EX_rt)).
REQ-006 Priority 1: when mem_busy=1, the block SHALL drive pc_hold=if_id_hold=pipe_freeze=1 and if_id_flush=id_ex_flush=0.
- A simultaneous EX_BranchTaken SHALL set pend_flush<=1.
- Next state SHALL be MEM_WAIT.
REQ-007 Priority 2: when mem_busy=0 and (EX_BranchTaken or pend_flush), the block SHALL drive if_id_flush=id_ex_flush=1 and pc_hold=if_id_hold=0, overriding load_use and ID_Jump.
REQ-008 Priority 3: when mem_busy=0, no branch flush is pending or active, and load_use=1, the block SHALL drive pc_hold=if_id_hold=id_ex_flush=1 for exactly that cycle.
REQ-009 Priority 4: when mem_busy=0 and only ID_Jump=1, the block SHALL drive if_id_flush=1 only.
REQ-010 With no condition active, all control outputs SHALL be 0.
REQ-011 In any cycle with mem_busy=0, pend_flush SHALL clear at the clock edge and the state SHALL return to RUN.
REQ-012 wait_cnt SHALL increment each MEM_WAIT cycle with mem_busy=1, saturating at 255, and clear on leaving MEM_WAIT.
- When the increment reaches 255, mem_timeout SHALL set.
- mem_timeout SHALL stay set until reset; it has no effect on pipeline control.
REQ-013 stall_cnt and flush_cnt SHALL increment by 1 on each edge where the respective output is 1, and saturate at 0xFFFFFFFF.

Reset
REQ-014 On a clk edge with reset=1, the block SHALL set state=RUN and clear pend_flush, wait_cnt, mem_timeout, stall_cnt and flush_cnt.
REQ-015 While reset=1, all control outputs SHALL be 0.
REQ-016 A reset in MEM_WAIT with pend_flush=1 SHALL discard the pending flush.

Structure
REQ-017 A shared package SHALL hold the state encoding (RUN=0, MEM_WAIT=1), TIMEOUT_LIMIT=255 and CNT_W=32.
REQ-018 The load_use comparison SHALL be a combinational sub-module named hazard_detect.
REQ-019 The FSM, pend_flush and the counters SHALL reside in pipeline_ctrl.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Load-use: EX_MemRead=1, EX_rt=8, ID_rs=8, ID_UsesRs=1 for 1 cycle -> pc_hold=if_id_hold=id_ex_flush=1 for 1 cycle; stall_cnt=1.
- Zero register: EX_MemRead=1, EX_rt=0, ID_rs=0, ID_UsesRs=1 -> all control outputs 0.
- Branch beats load-use: EX_BranchTaken=1 together with the load-use condition -> if_id_flush=id_ex_flush=1, pc_hold=0; flush_cnt=1.
- Deferred flush: mem_busy=1 for 3 cycles with EX_BranchTaken=1 in cycle 1 -> freeze for 3 cycles, no flush; cycle 4 (mem_busy=0) -> if_id_flush=id_ex_flush=1, then state=RUN.
- Timeout: mem_busy=1 for 300 cycles -> mem_timeout=1 from the 256th cycle, wait_cnt=255, pipe_freeze stays 1.
- Reset in MEM_WAIT: reset asserted in MEM_WAIT with pend_flush=1 -> next cycle, with mem_busy=0, all outputs 0 and counters 0.
